// File: rtl/jk_bank.sv
// jk_bank: WIDTH independent JK flip-flops with input synchronisers,
// tick prescaler, optional edge latching and synchronous parallel load.
module jk_bank #(
  parameter int WIDTH       = 4,
  parameter int DIV_BITS    = 26,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic [WIDTH-1:0] changed
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync_j;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync_k;
  logic [WIDTH-1:0]                  w_js;
  logic [WIDTH-1:0]                  w_ks;
  logic [WIDTH-1:0]                  w_cmd_j;
  logic [WIDTH-1:0]                  w_cmd_k;
  logic [WIDTH-1:0]                  w_q_next;
  logic [WIDTH-1:0]                  r_q;
  logic [WIDTH-1:0]                  r_changed;
  logic                              w_tick;

  // shift asynchronous j/k through the synchroniser chains
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_j <= '0;
      r_sync_k <= '0;
    end else begin
      r_sync_j <= {r_sync_j[SYNC_STAGES-2:0], j};
      r_sync_k <= {r_sync_k[SYNC_STAGES-2:0], k};
    end
  end

  assign w_js = r_sync_j[SYNC_STAGES-1];
  assign w_ks = r_sync_k[SYNC_STAGES-1];

  generate
    if (DIV_BITS == 0) begin : g_nodiv
      assign w_tick = ce & reset;
    end else begin : g_div
      localparam logic [DIV_BITS-1:0] CNT_ONE = 1;
      logic [DIV_BITS-1:0] r_cnt;

      // free-running prescaler, advances only on enabled cycles
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
        end else if (ce) begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end

      assign w_tick = ce & reset & (&r_cnt);
    end
  endgenerate

  generate
    if (EDGE_MODE != 0) begin : g_edge
      logic [WIDTH-1:0] r_js_d;
      logic [WIDTH-1:0] r_ks_d;
      logic [WIDTH-1:0] r_pend_j;
      logic [WIDTH-1:0] r_pend_k;
      logic [WIDTH-1:0] w_rise_j;
      logic [WIDTH-1:0] w_rise_k;

      assign w_rise_j = w_js & ~r_js_d;
      assign w_rise_k = w_ks & ~r_ks_d;

      // remember rising edges until the next tick or load consumes them
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_js_d   <= '0;
          r_ks_d   <= '0;
          r_pend_j <= '0;
          r_pend_k <= '0;
        end else begin
          r_js_d <= w_js;
          r_ks_d <= w_ks;
          if (load || w_tick) begin
            r_pend_j <= '0;
            r_pend_k <= '0;
          end else begin
            r_pend_j <= r_pend_j | w_rise_j;
            r_pend_k <= r_pend_k | w_rise_k;
          end
        end
      end

      assign w_cmd_j = r_pend_j | w_rise_j;
      assign w_cmd_k = r_pend_k | w_rise_k;
    end else begin : g_level
      assign w_cmd_j = w_js;
      assign w_cmd_k = w_ks;
    end
  endgenerate

  // load beats tick; on tick apply the JK characteristic per channel
  always_comb begin
    w_q_next = r_q;
    if (load) begin
      w_q_next = d;
    end else if (w_tick) begin
      w_q_next = (w_cmd_j & ~r_q) | (~w_cmd_k & r_q);
    end
  end

  // register outputs and flag channels whose value moved
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q       <= '0;
      r_changed <= '0;
    end else begin
      r_q       <= w_q_next;
      r_changed <= w_q_next ^ r_q;
    end
  end

  assign q       = r_q;
  assign changed = r_changed;
  assign tick    = w_tick;

endmodule

// File: tb/tb_jk_bank.sv
// tb_jk_bank: directed scoreboard bench over four jk_bank
// configurations (level, prescaled, edge, wide).
module tb_jk_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_ce, a_ld, a_tick;
  logic [3:0] a_j, a_k, a_d, a_q, a_chg;
  logic       b_ce, b_ld, b_tick;
  logic [3:0] b_j, b_k, b_d, b_q, b_chg;
  logic       c_ce, c_ld, c_tick;
  logic [3:0] c_j, c_k, c_d, c_q, c_chg;
  logic       d_ce, d_ld, d_tick;
  logic [7:0] d_j, d_k, d_d, d_q, d_chg;

  jk_bank #(.WIDTH(4), .DIV_BITS(0), .SYNC_STAGES(2), .EDGE_MODE(0)) u_a (
    .clk(clk), .reset(rst_n), .ce(a_ce), .j(a_j), .k(a_k),
    .load(a_ld), .d(a_d), .q(a_q), .tick(a_tick), .changed(a_chg));

  jk_bank #(.WIDTH(4), .DIV_BITS(2), .SYNC_STAGES(2), .EDGE_MODE(0)) u_b (
    .clk(clk), .reset(rst_n), .ce(b_ce), .j(b_j), .k(b_k),
    .load(b_ld), .d(b_d), .q(b_q), .tick(b_tick), .changed(b_chg));

  jk_bank #(.WIDTH(4), .DIV_BITS(3), .SYNC_STAGES(2), .EDGE_MODE(1)) u_c (
    .clk(clk), .reset(rst_n), .ce(c_ce), .j(c_j), .k(c_k),
    .load(c_ld), .d(c_d), .q(c_q), .tick(c_tick), .changed(c_chg));

  jk_bank #(.WIDTH(8), .DIV_BITS(0), .SYNC_STAGES(2), .EDGE_MODE(0)) u_d (
    .clk(clk), .reset(rst_n), .ce(d_ce), .j(d_j), .k(d_k),
    .load(d_ld), .d(d_d), .q(d_q), .tick(d_tick), .changed(d_chg));

  logic [31:0] sb[$];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_tot++;
    if (sb.size() == 0) begin
      $error("FAIL %s: got %0h, scoreboard empty", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic rst_cycle();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] seg_jk [5];
  logic       seg_q  [5];
  logic       seg_c  [5];
  int         ntick, first_t, last_t;
  logic [3:0] q6, q7;

  initial begin
    rst_n = 1'b0;
    a_ce = 1'b1; a_ld = 1'b0; a_j = '0; a_k = '0; a_d = '0;
    b_ce = 1'b0; b_ld = 1'b0; b_j = '0; b_k = '0; b_d = '0;
    c_ce = 1'b0; c_ld = 1'b0; c_j = '0; c_k = '0; c_d = '0;
    d_ce = 1'b0; d_ld = 1'b0; d_j = '0; d_k = '0; d_d = '0;

    // reset state, ce held high on the undivided bank
    repeat (3) @(negedge clk);
    #1;
    push(0); chk("rst_a_q", a_q);
    push(0); chk("rst_a_tick", a_tick);
    push(0); chk("rst_a_chg", a_chg);
    push(0); chk("rst_c_q", c_q);
    a_ce = 1'b0;

    // reset mid-run on the DIV_BITS=2 bank
    b_ce = 1'b1; b_j = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    #1;
    push(1);     chk("pre_rst_tick", b_tick);
    push(4'hF);  chk("pre_rst_q", b_q);
    rst_n = 1'b0;
    #1;
    push(0); chk("rst_mid_tick", b_tick);
    push(0); chk("rst_mid_q", b_q);
    push(0); chk("rst_mid_chg", b_chg);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    push(0); chk("rel_tick0", b_tick);
    @(negedge clk); #1;
    push(0); chk("rel_tick1", b_tick);
    @(negedge clk); #1;
    push(0); chk("rel_tick2", b_tick);
    @(negedge clk); #1;
    push(1); chk("rel_tick3", b_tick);
    push(0); chk("rel_q3", b_q);
    @(negedge clk); #1;
    push(4'hF); chk("rel_q4", b_q);
    push(4'hF); chk("rel_chg4", b_chg);
    @(negedge clk); #1;
    push(0); chk("rel_chg5", b_chg);

    // ce held low: no ticks, q never moves
    rst_cycle();
    b_ce = 1'b0;
    ntick = 0;
    push(0); push(0);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (b_tick) ntick++;
      @(negedge clk);
    end
    #1;
    chk("ce0_ticks", ntick);
    chk("ce0_q", b_q);

    // ce alternating: tick every 8 clocks, first at cycle 6
    rst_cycle();
    ntick = 0; first_t = -1; last_t = -1;
    q6 = '0; q7 = '0;
    push(4); push(6); push(30); push(0); push(4'hF);
    for (int i = 0; i < 32; i++) begin
      b_ce = (i % 2 == 0);
      #1;
      if (b_tick) begin
        ntick++;
        if (first_t < 0) first_t = i;
        last_t = i;
      end
      if (i == 6) q6 = b_q;
      if (i == 7) q7 = b_q;
      @(negedge clk);
    end
    chk("gate_nticks", ntick);
    chk("gate_first", first_t);
    chk("gate_last", last_t);
    chk("gate_q_before", q6);
    chk("gate_q_after", q7);
    b_ce = 1'b0;

    // level truth table on channel 0, one tick per segment
    seg_jk = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b00};
    seg_q  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    seg_c  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst_cycle();
    for (int s = 0; s < 5; s++) begin
      a_j[0] = seg_jk[s][1];
      a_k[0] = seg_jk[s][0];
      a_ce = 1'b0;
      push(seg_q[s]); push(seg_c[s]); push(0);
      repeat (2) @(negedge clk);
      a_ce = 1'b1;
      @(negedge clk);
      a_ce = 1'b0;
      #1;
      chk("tt_q", a_q[0]);
      chk("tt_chg", a_chg[0]);
      @(negedge clk); #1;
      chk("tt_chg_clr", a_chg[0]);
    end

    // load wins over a tick in level mode
    a_j = 4'hF; a_k = 4'h0; a_ce = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    push(4'hF); chk("ld_pre_q", a_q);
    a_ld = 1'b1; a_d = 4'hA;
    #1;
    push(1); chk("ld_tick", a_tick);
    @(negedge clk);
    a_ld = 1'b0;
    #1;
    push(4'hA); chk("ld_q", a_q);
    push(4'h5); chk("ld_chg", a_chg);
    a_ce = 1'b0; a_j = '0;

    // edge latching, toggle from separate j/k rises, load drops pending
    rst_cycle();
    c_ce = 1'b1; c_d = 4'hA;
    for (int i = 0; i < 41; i++) begin
      c_j  = (i == 9 || i == 10) ? 4'b0110 :
             (i == 29 || i == 30) ? 4'b0001 : 4'b0000;
      c_k  = (i == 11 || i == 12) ? 4'b0010 :
             (i == 25 || i == 26) ? 4'b1000 : 4'b0000;
      c_ld = (i == 31);
      #1;
      if (i == 15) begin
        push(0); chk("edge_q_before", c_q);
        push(1); chk("edge_tick15", c_tick);
      end
      if (i == 16) begin
        push(4'b0110); chk("edge_q_after", c_q);
        push(4'b0110); chk("edge_chg", c_chg);
      end
      if (i == 24) begin
        push(4'b0110); chk("edge_idle_q", c_q);
        push(0);       chk("edge_idle_chg", c_chg);
      end
      if (i == 31) begin
        push(1); chk("edge_ld_tick", c_tick);
      end
      if (i == 32) begin
        push(4'hA); chk("edge_ld_q", c_q);
        push(4'hC); chk("edge_ld_chg", c_chg);
      end
      if (i == 40) begin
        push(4'hA); chk("edge_drop_q", c_q);
      end
      @(negedge clk);
    end
    c_ce = 1'b0; c_j = '0; c_k = '0; c_ld = 1'b0;

    // width 8, single tick then a repeat that changes nothing
    rst_cycle();
    d_j = 8'h55; d_k = 8'hAA; d_ce = 1'b0;
    repeat (2) @(negedge clk);
    d_ce = 1'b1;
    #1;
    push(0); chk("wide_q_pre", d_q);
    @(negedge clk);
    d_ce = 1'b0;
    #1;
    push(8'h55); chk("wide_q", d_q);
    push(8'h55); chk("wide_chg", d_chg);
    @(negedge clk); #1;
    push(8'h55); chk("wide_q_hold", d_q);
    push(0);     chk("wide_chg_clr", d_chg);
    d_ce = 1'b1;
    @(negedge clk);
    d_ce = 1'b0;
    #1;
    push(8'h55); chk("wide_q_again", d_q);
    push(0);     chk("wide_chg_same", d_chg);

    if (sb.size() != 0) begin
      n_tot++;
      $error("FAIL sb_drain: got %0d left want 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/jk_bank.md
# jk_bank

Parametrised bank of WIDTH independent JK flip-flops for board-level use on the Basys3. Switch and button inputs pass through per-channel synchronisers. JK commands are applied on ticks from an internal prescaler, so LED outputs change at a human-visible rate. An optional edge mode latches button presses between ticks so they are never lost. A synchronous parallel load and per-channel change pulses support use as a small register file feeding downstream logic.

## Interface
- WIDTH, 4, number of JK channels (≥1)
- DIV_BITS, 26, prescaler width; tick period 2^DIV_BITS enabled cycles; 0 means tick on every enabled cycle
- SYNC_STAGES, 2, synchroniser depth on j/k (≥2)
- EDGE_MODE, 0, 0 = level mode (apply synchronised j/k on tick); 1 = edge mode (latch rising edges, apply on tick)

- clk  in  1  100 MHz system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- ce  in  1  prescaler count enable; no ticks while low
- j  in  WIDTH  per-channel J, asynchronous to clk
- k  in  WIDTH  per-channel K, asynchronous to clk
- load  in  1  synchronous parallel load strobe, already in the clk domain
- d  in  WIDTH  load data
- q  out  WIDTH  flip-flop outputs (registered)
- tick  out  1  one-cycle prescaler wrap pulse (combinational from counter and ce)
- changed  out  WIDTH  registered one-cycle pulse per channel when q[i] toggles value

## Operation
- Reset (reset=0): q, changed, prescaler counter, synchroniser stages and pending registers all 0. tick=0 while in reset.
- Synchroniser: j and k each pass through SYNC_STAGES flops; js/ks denote the final stage.
- Prescaler: DIV_BITS-bit counter increments when ce=1 and wraps from all-ones to 0.
  - tick = ce && (counter == all-ones).
  - DIV_BITS=0: tick = ce.
- Level mode, on a cycle with tick=1, per channel {js,ks}:
  - 00 hold
  - 01 q<=0
  - 10 q<=1
  - 11 q<=~q
- Edge mode:
  - Rising edges of js (ks) set pend_j[i] (pend_k[i]).
  - On tick, the JK table is applied using pend_j|rise_j and pend_k|rise_k. An edge occurring in the tick cycle itself is counted. Both pending bits then clear.
  - Multiple rises of the same input between ticks collapse to one command.
  - Rise on j and k for the same channel between ticks gives a toggle.
- Priority is highest first:
  - load=1: q<=d for all channels, regardless of tick. In edge mode, all pending bits clear, and edges detected that cycle are discarded.
  - tick: JK update.
  - Otherwise hold.
- Prescaler keeps running through load.
- changed[i] <= q_next[i] ^ q[i]. It is 0 for hold, and 0 for a set or reset that does not alter the value.

## Timing
- Level mode, DIV_BITS=0, ce=1: j/k stable before edge E1 gives q updated at edge E(SYNC_STAGES+1). This is 3 edges for the default.
- With a prescaler, the update happens at the first tick cycle whose js/ks reflect the input.
- Worst-case latency is SYNC_STAGES + 2^DIV_BITS cycles.
- load: q=d and changed valid one edge after the load cycle.
- changed asserts in the same cycle q shows the new value, for exactly one cycle.
- Reset asserted mid-operation clears everything immediately. After reset releases, the first tick occurs at the 2^DIV_BITS-th enabled edge.
- Inputs j/k shorter than one clk period may be missed in both modes. Edge mode requires js high for ≥1 cycle.

## Test plan
- Reset: WIDTH=4, DIV_BITS=2, SYNC_STAGES=2. Drive j=4'hF, pulse reset low mid-run -> q=0, changed=0, tick=0 immediately and counter restarts; first tick on the 4th enabled edge after release.
- Level truth table: DIV_BITS=0, {j,k}=10,01,11,11,00 each held 4 cycles on channel 0 -> q[0] sequence 1,0,1,0,0; changed[0] pulses on each real change only.
- Prescaler gating: DIV_BITS=2, j=4'hF, ce toggled 1/0 alternately -> tick every 8 clk cycles, q=4'hF after the first tick; ce=0 constant -> q stays 0.
- Edge latching: EDGE_MODE=1, DIV_BITS=3. Pulse j[2] high 2 cycles midway between ticks -> q[2]=1 at the next tick, not before. Pulse j[1] and k[1] in the same gap -> q[1] toggles once.
- Load priority: load=1 with d=4'hA in the same cycle as tick and j=4'hF -> q=4'hA. Pending edges are dropped, so the next tick with no new edges leaves q=4'hA.
- Width scaling: WIDTH=8, j=8'h55, k=8'hAA, one tick -> q=8'h55, changed=8'h55 for one cycle.
